// File: rtl/tri_setup_if.sv
// tri_setup_if: triangle-in / setup-record-out handshake bundle.
// master drives triangles and accepts records; slave is the setup stage.
interface tri_setup_if #(
   parameter int COORD_W = 10,
   parameter int CNT_W   = 16
);
   logic                        tri_valid;
   logic                        tri_ready;
   logic [COORD_W-1:0]          ax, ay, bx, by, cx, cy;
   logic                        setup_valid;
   logic                        setup_ready;
   logic [COORD_W-1:0]          min_x, max_x, min_y, max_y;
   logic signed [COORD_W:0]     e0_a, e1_a, e2_a;
   logic signed [COORD_W:0]     e0_b, e1_b, e2_b;
   logic signed [2*COORD_W+1:0] e0_c, e1_c, e2_c;
   logic signed [2*COORD_W+3:0] area2;
   logic [CNT_W-1:0]            drop_cnt;

   modport master (
      output tri_valid, ax, ay, bx, by, cx, cy, setup_ready,
      input  tri_ready, setup_valid, min_x, max_x, min_y, max_y,
      input  e0_a, e1_a, e2_a, e0_b, e1_b, e2_b, e0_c, e1_c, e2_c,
      input  area2, drop_cnt
   );

   modport slave (
      input  tri_valid, ax, ay, bx, by, cx, cy, setup_ready,
      output tri_ready, setup_valid, min_x, max_x, min_y, max_y,
      output e0_a, e1_a, e2_a, e0_b, e1_b, e2_b, e0_c, e1_c, e2_c,
      output area2, drop_cnt
   );
endinterface

// File: rtl/tri_setup.sv
// tri_setup: bbox, edge functions and doubled area for one triangle at a time.
// Define TRI_BACKFACE_CULL_EN to drop clockwise triangles instead of flipping them.
module tri_setup #(
   parameter int SCR_W   = 640,
   parameter int SCR_H   = 400,
   parameter int COORD_W = 10,
   parameter int CNT_W   = 16
) (
   input logic        clk,
   input logic        rst_n,
   tri_setup_if.slave bus
);
   localparam int EW = COORD_W + 1;
   localparam int CW = 2 * COORD_W + 2;
   localparam int AW = 2 * COORD_W + 4;
   localparam logic [COORD_W-1:0] XLIM = COORD_W'(SCR_W - 1);
   localparam logic [COORD_W-1:0] YLIM = COORD_W'(SCR_H - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_C0, S_C1, S_C2, S_AREA, S_OUT
   } state_t;

   state_t state;

   logic [COORD_W-1:0]   vax, vay, vbx, vby, vcx, vcy;
   logic signed [EW-1:0] a0, a1, a2, b0, b1, b2;
   logic signed [CW-1:0] c0, c1, c2;
   logic signed [AW-1:0] area;
   logic [COORD_W-1:0]   m0x, m0y, m1x, m1y;
   logic [2*COORD_W-1:0] p0, p1;
   logic signed [CW-1:0] cdiff;
   logic signed [AW-1:0] area_sum;
   logic [COORD_W-1:0]   bb_min_x, bb_max_x, bb_min_y, bb_max_y;
   logic                 drop;

   function automatic logic signed [EW-1:0] diff(
      input logic [COORD_W-1:0] p, q);
      return $signed({1'b0, p}) - $signed({1'b0, q});
   endfunction

   function automatic logic [COORD_W-1:0] min3(
      input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p < q) ? p : q;
      return (r < m) ? r : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(
      input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p > q) ? p : q;
      return (r > m) ? r : m;
   endfunction

   function automatic logic [COORD_W-1:0] clip(
      input logic [COORD_W-1:0] v, lim);
      return (v > lim) ? lim : v;
   endfunction

   // One multiplier pair, time-shared across the three edge constants
   always_comb begin
      m0x = '0;
      m0y = '0;
      m1x = '0;
      m1y = '0;
      unique case (state)
         S_C0: begin m0x = vbx; m0y = vcy; m1x = vcx; m1y = vby; end
         S_C1: begin m0x = vcx; m0y = vay; m1x = vax; m1y = vcy; end
         S_C2: begin m0x = vax; m0y = vby; m1x = vbx; m1y = vay; end
         default: ;
      endcase
   end

   assign p0 = {{COORD_W{1'b0}}, m0x} * {{COORD_W{1'b0}}, m0y};
   assign p1 = {{COORD_W{1'b0}}, m1x} * {{COORD_W{1'b0}}, m1y};
   assign cdiff = $signed({2'b00, p0}) - $signed({2'b00, p1});
   assign area_sum = AW'(c0) + AW'(c1) + AW'(c2);

   assign bb_min_x = clip(min3(vax, vbx, vcx), XLIM);
   assign bb_max_x = clip(max3(vax, vbx, vcx), XLIM);
   assign bb_min_y = clip(min3(vay, vby, vcy), YLIM);
   assign bb_max_y = clip(max3(vay, vby, vcy), YLIM);

`ifdef TRI_BACKFACE_CULL_EN
   assign drop = (area == '0) || area[AW-1];
`else
   assign drop = (area == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         {vax, vay, vbx, vby, vcx, vcy} <= '0;
         {a0, a1, a2, b0, b1, b2} <= '0;
         {c0, c1, c2}    <= '0;
         area            <= '0;
         bus.tri_ready   <= 1'b1;
         bus.setup_valid <= 1'b0;
         bus.min_x       <= '0;
         bus.max_x       <= '0;
         bus.min_y       <= '0;
         bus.max_y       <= '0;
         bus.e0_a        <= '0;
         bus.e1_a        <= '0;
         bus.e2_a        <= '0;
         bus.e0_b        <= '0;
         bus.e1_b        <= '0;
         bus.e2_b        <= '0;
         bus.e0_c        <= '0;
         bus.e1_c        <= '0;
         bus.e2_c        <= '0;
         bus.area2       <= '0;
         bus.drop_cnt    <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (bus.tri_valid) begin
               vax           <= bus.ax;
               vay           <= bus.ay;
               vbx           <= bus.bx;
               vby           <= bus.by;
               vcx           <= bus.cx;
               vcy           <= bus.cy;
               bus.tri_ready <= 1'b0;
               state         <= S_C0;
            end
            S_C0: begin
               a0    <= diff(vby, vcy);
               b0    <= diff(vcx, vbx);
               c0    <= cdiff;
               state <= S_C1;
            end
            S_C1: begin
               a1    <= diff(vcy, vay);
               b1    <= diff(vax, vcx);
               c1    <= cdiff;
               state <= S_C2;
            end
            S_C2: begin
               a2    <= diff(vay, vby);
               b2    <= diff(vbx, vax);
               c2    <= cdiff;
               state <= S_AREA;
            end
            S_AREA: begin
               area  <= area_sum;
               state <= S_OUT;
            end
            S_OUT: if (!bus.setup_valid) begin
               if (drop) begin
                  if (bus.drop_cnt != '1)
                     bus.drop_cnt <= bus.drop_cnt + CNT_W'(1);
                  bus.tri_ready <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  bus.min_x       <= bb_min_x;
                  bus.max_x       <= bb_max_x;
                  bus.min_y       <= bb_min_y;
                  bus.max_y       <= bb_max_y;
`ifdef TRI_BACKFACE_CULL_EN
                  bus.e0_a        <= a0;
                  bus.e1_a        <= a1;
                  bus.e2_a        <= a2;
                  bus.e0_b        <= b0;
                  bus.e1_b        <= b1;
                  bus.e2_b        <= b2;
                  bus.e0_c        <= c0;
                  bus.e1_c        <= c1;
                  bus.e2_c        <= c2;
                  bus.area2       <= area;
`else
                  // Clockwise input: flip every sign so inside stays E>=0
                  bus.e0_a        <= area[AW-1] ? -a0 : a0;
                  bus.e1_a        <= area[AW-1] ? -a1 : a1;
                  bus.e2_a        <= area[AW-1] ? -a2 : a2;
                  bus.e0_b        <= area[AW-1] ? -b0 : b0;
                  bus.e1_b        <= area[AW-1] ? -b1 : b1;
                  bus.e2_b        <= area[AW-1] ? -b2 : b2;
                  bus.e0_c        <= area[AW-1] ? -c0 : c0;
                  bus.e1_c        <= area[AW-1] ? -c1 : c1;
                  bus.e2_c        <= area[AW-1] ? -c2 : c2;
                  bus.area2       <= area[AW-1] ? -area : area;
`endif
                  bus.setup_valid <= 1'b1;
               end
            end else if (bus.setup_ready) begin
               bus.setup_valid <= 1'b0;
               bus.tri_ready   <= 1'b1;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tri_setup.sv
// tb_tri_setup: directed vector table, stall and reset sequences,
// then random triangles against a cross-product reference model.
module tb_tri_setup;
   localparam int SCR_W   = 640;
   localparam int SCR_H   = 400;
   localparam int COORD_W = 10;
   localparam int CNT_W   = 16;

`ifdef TRI_BACKFACE_CULL_EN
   localparam bit CULL = 1'b1;
`else
   localparam bit CULL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   tri_setup_if #(.COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

   tri_setup #(
      .SCR_W(SCR_W), .SCR_H(SCR_H),
      .COORD_W(COORD_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int drops = 0;

   typedef struct {
      int a0, a1, a2, b0, b1, b2, c0, c1, c2;
      int area, mnx, mxx, mny, mxy;
      bit drop;
   } exp_t;

   typedef struct {
      int ax, ay, bx, by, cx, cy;
      bit drop, cw;
      int area, mnx, mxx, mny, mxy;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   function automatic int imin3(input int p, q, r);
      int m;
      m = (p < q) ? p : q;
      return (r < m) ? r : m;
   endfunction

   function automatic int imax3(input int p, q, r);
      int m;
      m = (p > q) ? p : q;
      return (r > m) ? r : m;
   endfunction

   function automatic int lim(input int v, input int top);
      return (v > top) ? top : v;
   endfunction

   // Edge k runs from vertex (k+1)%3 to (k+2)%3; area from the cross product
   function automatic exp_t model(input int ax, ay, bx, by, cx, cy);
      exp_t e;
      int x[3], y[3], ca[3], cb[3], cc[3];
      int s, ar;
      x[0] = ax; x[1] = bx; x[2] = cx;
      y[0] = ay; y[1] = by; y[2] = cy;
      ar = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
      s = (ar < 0) ? -1 : 1;
      for (int k = 0; k < 3; k++) begin
         int i, j;
         i = (k + 1) % 3;
         j = (k + 2) % 3;
         ca[k] = s * (y[i] - y[j]);
         cb[k] = s * (x[j] - x[i]);
         cc[k] = s * (x[i] * y[j] - x[j] * y[i]);
      end
      e.a0 = ca[0]; e.a1 = ca[1]; e.a2 = ca[2];
      e.b0 = cb[0]; e.b1 = cb[1]; e.b2 = cb[2];
      e.c0 = cc[0]; e.c1 = cc[1]; e.c2 = cc[2];
      e.area = s * ar;
      e.drop = (ar == 0) || (CULL && ar < 0);
      e.mnx = lim(imin3(ax, bx, cx), SCR_W - 1);
      e.mxx = lim(imax3(ax, bx, cx), SCR_W - 1);
      e.mny = lim(imin3(ay, by, cy), SCR_H - 1);
      e.mxy = lim(imax3(ay, by, cy), SCR_H - 1);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rec(input exp_t e);
      chk("e0_a", bus.e0_a, e.a0);
      chk("e1_a", bus.e1_a, e.a1);
      chk("e2_a", bus.e2_a, e.a2);
      chk("e0_b", bus.e0_b, e.b0);
      chk("e1_b", bus.e1_b, e.b1);
      chk("e2_b", bus.e2_b, e.b2);
      chk("e0_c", bus.e0_c, e.c0);
      chk("e1_c", bus.e1_c, e.c1);
      chk("e2_c", bus.e2_c, e.c2);
      chk("area2", bus.area2, e.area);
      chk("min_x", bus.min_x, e.mnx);
      chk("max_x", bus.max_x, e.mxx);
      chk("min_y", bus.min_y, e.mny);
      chk("max_y", bus.max_y, e.mxy);
   endtask

   task automatic chk_reset();
      chk("rst_tri_ready", bus.tri_ready, 1);
      chk("rst_setup_valid", bus.setup_valid, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      chk("rst_min_x", bus.min_x, 0);
      chk("rst_max_x", bus.max_x, 0);
      chk("rst_min_y", bus.min_y, 0);
      chk("rst_max_y", bus.max_y, 0);
      chk("rst_e0_a", bus.e0_a, 0);
      chk("rst_e1_b", bus.e1_b, 0);
      chk("rst_e2_c", bus.e2_c, 0);
      chk("rst_area2", bus.area2, 0);
   endtask

   task automatic scramble();
      bus.ax = COORD_W'($urandom);
      bus.ay = COORD_W'($urandom);
      bus.bx = COORD_W'($urandom);
      bus.by = COORD_W'($urandom);
      bus.cx = COORD_W'($urandom);
      bus.cy = COORD_W'($urandom);
   endtask

   // Present one triangle, return cycles until record/drop and whether dropped
   task automatic send(input int ax, ay, bx, by, cx, cy,
                       output int lat, output bit dropped);
      int n;
      n = 0;
      while (!bus.tri_ready && n < 50) begin
         tick();
         n++;
      end
      chk("ready_before_send", bus.tri_ready, 1);
      bus.ax = COORD_W'(ax);
      bus.ay = COORD_W'(ay);
      bus.bx = COORD_W'(bx);
      bus.by = COORD_W'(by);
      bus.cx = COORD_W'(cx);
      bus.cy = COORD_W'(cy);
      bus.tri_valid = 1'b1;
      tick();
      bus.tri_valid = 1'b0;
      scramble();
      chk("ready_fall", bus.tri_ready, 0);
      lat = 0;
      dropped = 1'b0;
      for (int t = 1; t <= 20 && lat == 0; t++) begin
         tick();
         if (bus.setup_valid) begin
            lat = t;
         end else if (bus.tri_ready) begin
            lat = t;
            dropped = 1'b1;
         end
      end
      chk("latency", lat, 5);
   endtask

   task automatic recv(input int stall);
      bus.setup_ready = 1'b0;
      repeat (stall) tick();
      bus.setup_ready = 1'b1;
      tick();
      bus.setup_ready = 1'b0;
      chk("valid_fall", bus.setup_valid, 0);
      chk("ready_rise", bus.tri_ready, 1);
   endtask

   // Returns 1 when a record is pending on the output
   task automatic run_one(input int ax, ay, bx, by, cx, cy,
                          output exp_t e, output bit pending);
      int lat;
      bit dr;
      e = model(ax, ay, bx, by, cx, cy);
      send(ax, ay, bx, by, cx, cy, lat, dr);
      chk("drop", dr, e.drop);
      if (e.drop && drops < 65535) drops++;
      chk("drop_cnt", bus.drop_cnt, drops);
      pending = (lat != 0) && !dr;
      if (pending) chk_rec(e);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit pend;
      int lat;
      bit dr;

      tbl[0] = '{1, 1, 200, 100, 50, 50, 0, 0, 4900, 1, 200, 1, 100};
      tbl[1] = '{1, 1, 50, 50, 200, 100, 0, 1, 4900, 1, 200, 1, 100};
      tbl[2] = '{0, 0, 10, 10, 20, 20, 1, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{700, 450, 10, 10, 10, 400, 0, 1, 269100, 10, 639, 10, 399};
      tbl[4] = '{1023, 0, 0, 1023, 0, 0, 0, 0, 1046529, 0, 639, 0, 399};
      tbl[5] = '{1023, 1023, 1023, 1023, 5, 5, 1, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      tbl[7] = '{639, 399, 639, 0, 0, 399, 0, 1, 254961, 0, 639, 0, 399};

      bus.tri_valid = 1'b0;
      bus.setup_ready = 1'b0;
      scramble();
      tick();
      tick();
      chk_reset();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         bit want_drop;
         want_drop = tbl[i].drop || (CULL && tbl[i].cw);
         run_one(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by,
                 tbl[i].cx, tbl[i].cy, e, pend);
         chk("tbl_drop", int'(e.drop), int'(want_drop));
         if (pend) begin
            chk("tbl_area", bus.area2, tbl[i].area);
            chk("tbl_min_x", bus.min_x, tbl[i].mnx);
            chk("tbl_max_x", bus.max_x, tbl[i].mxx);
            chk("tbl_min_y", bus.min_y, tbl[i].mny);
            chk("tbl_max_y", bus.max_y, tbl[i].mxy);
            if (i == 0) begin
               chk("ex1_a0", bus.e0_a, 50);
               chk("ex1_b0", bus.e0_b, -150);
               chk("ex1_c0", bus.e0_c, 5000);
               chk("ex1_c1", bus.e1_c, 0);
               chk("ex1_c2", bus.e2_c, -100);
            end
            recv(i % 3);
         end else begin
            chk("drop_ready", bus.tri_ready, 1);
            chk("drop_no_valid", bus.setup_valid, 0);
         end
      end

      // Stalled output: record frozen, new triangles refused
      run_one(30, 20, 300, 250, 100, 390, e, pend);
      if (pend) begin
         bus.tri_valid = 1'b1;
         scramble();
         for (int t = 0; t < 10; t++) begin
            tick();
            chk("hold_valid", bus.setup_valid, 1);
            chk("hold_ready", bus.tri_ready, 0);
            chk("hold_area", bus.area2, e.area);
            chk("hold_e1_c", bus.e1_c, e.c1);
            chk("hold_max_y", bus.max_y, e.mxy);
         end
         bus.tri_valid = 1'b0;
         recv(0);
      end

      // Back-to-back: record after a drop keeps previous record outputs
      run_one(5, 5, 5, 5, 5, 5, e, pend);
      chk("drop_keeps_area", bus.area2, 83800);
      run_one(100, 100, 400, 100, 100, 300, e, pend);
      if (pend) recv(0);

      // Reset while mid-computation
      bus.ax = 10'd3;
      bus.ay = 10'd4;
      bus.bx = 10'd90;
      bus.by = 10'd7;
      bus.cx = 10'd20;
      bus.cy = 10'd80;
      bus.tri_valid = 1'b1;
      tick();
      bus.tri_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk_reset();
      drops = 0;
      tick();
      rst_n = 1'b1;
      tick();
      run_one(3, 4, 90, 7, 20, 80, e, pend);
      if (pend) recv(1);

      for (int n = 0; n < 150; n++) begin
         int v[6];
         int top;
         top = ($urandom_range(0, 3) == 0) ? 4 : 1023;
         for (int k = 0; k < 6; k++) v[k] = int'($urandom_range(0, top));
         run_one(v[0], v[1], v[2], v[3], v[4], v[5], e, pend);
         if (pend) recv(int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
